// File: rtl/vec_pkg.sv
// Shared constants and types for the vector element sequencer.
package vec_pkg;

  localparam int unsigned VLEN = 5;

  localparam logic [3:0] BANK0_BASE = 4'd0;
  localparam logic [3:0] BANK1_BASE = 4'd5;

  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpDot  = 2'b01,
    OpSmul = 2'b10,
    OpVadd = 2'b11
  } op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/vec_elem_alu.sv
// Per-element arithmetic for the vector sequencer; all results wrap modulo 2^DATA_W.
module vec_elem_alu #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] scalar,
  input  logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] result
);
  import vec_pkg::*;

  always_comb begin
    result = '0;
    case (op_e'(op))
      OpDot:   result = acc + a * b;
      OpSmul:  result = a * scalar;
      OpVadd:  result = a + b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vec_element_seq.sv
// Steps one vector op element by element over a 5-register bank, writing results
// back through a registered register-file port.
module vec_element_seq #(
  parameter int unsigned VLEN   = vec_pkg::VLEN,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              z,
  input  logic              bank,
  input  logic [3:0]        rd,
  input  logic [DATA_W-1:0] scalar,
  input  logic              step,
  input  logic [DATA_W-1:0] elem_a,
  input  logic [DATA_W-1:0] elem_b,
  output logic [3:0]        rm_cntr,
  output logic              rm_cntr_done,
  output logic [3:0]        src_a_idx,
  output logic [3:0]        src_b_idx,
  output logic              busy,
  output logic              wr_en,
  output logic [3:0]        wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] acc,
  output logic              done
);
  import vec_pkg::*;

  localparam logic [3:0] LastOff = 4'(VLEN - 1);

  // Assert asynchronously, release two edges later so state never sees a runt release.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  state_e            r_state, w_state_nxt;
  op_e               r_op, w_op_nxt;
  logic [3:0]        r_rd, w_rd_nxt;
  logic [DATA_W-1:0] r_scalar, w_scalar_nxt;
  logic [3:0]        r_cntr, w_cntr_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [3:0]        r_wr_idx, w_wr_idx_nxt;
  logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
  logic              r_done, w_done_nxt;
  logic [DATA_W-1:0] w_alu;
  logic              w_last;

  vec_elem_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (r_op),
    .a      (elem_a),
    .b      (elem_b),
    .scalar (r_scalar),
    .acc    (r_acc),
    .result (w_alu)
  );

  assign w_last = (r_cntr == BANK0_BASE + LastOff) || (r_cntr == BANK1_BASE + LastOff);

  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_rd_nxt      = r_rd;
    w_scalar_nxt  = r_scalar;
    w_cntr_nxt    = r_cntr;
    w_acc_nxt     = r_acc;
    w_wr_en_nxt   = 1'b0;
    w_wr_idx_nxt  = r_wr_idx;
    w_wr_data_nxt = r_wr_data;
    w_done_nxt    = 1'b0;
    case (r_state)
      StIdle: begin
        if (start && (op_e'(op) != OpNone)) begin
          w_state_nxt  = StRun;
          w_op_nxt     = op_e'(op);
          w_rd_nxt     = rd;
          w_scalar_nxt = scalar;
          w_cntr_nxt   = bank ? BANK1_BASE : BANK0_BASE;
          if ((op_e'(op) == OpDot) && z) w_acc_nxt = '0;
        end
      end
      StRun: begin
        if (step) begin
          if (r_op == OpDot) begin
            w_acc_nxt = w_alu;
            if (w_last) begin
              w_wr_en_nxt   = 1'b1;
              w_wr_idx_nxt  = r_rd;
              w_wr_data_nxt = w_alu;
            end
          end else begin
            w_wr_en_nxt   = 1'b1;
            w_wr_idx_nxt  = r_cntr;
            w_wr_data_nxt = w_alu;
          end
          if (w_last) begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end else begin
            w_cntr_nxt = r_cntr + 4'd1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= StIdle;
      r_op      <= OpNone;
      r_rd      <= 4'd0;
      r_scalar  <= '0;
      r_cntr    <= 4'd0;
      r_acc     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_idx  <= 4'd0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_rd      <= w_rd_nxt;
      r_scalar  <= w_scalar_nxt;
      r_cntr    <= w_cntr_nxt;
      r_acc     <= w_acc_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_idx  <= w_wr_idx_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign rm_cntr      = r_cntr;
  assign rm_cntr_done = w_last;
  assign src_a_idx    = r_cntr;
  assign src_b_idx    = (r_cntr >= 4'd5) ? (r_cntr - 4'd5) : (r_cntr + 4'd5);
  assign busy         = (r_state == StRun);
  assign wr_en        = r_wr_en;
  assign wr_idx       = r_wr_idx;
  assign wr_data      = r_wr_data;
  assign acc          = r_acc;
  assign done         = r_done;

endmodule

// File: tb/tb_vec_element_seq.sv
// Directed bench for vec_element_seq with a per-cycle reference model and literal spot checks.
module tb_vec_element_seq;
  localparam int DW = 32;
  localparam int NE = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          z = 1'b0;
  logic          bank = 1'b0;
  logic [3:0]    rd = 4'd0;
  logic [DW-1:0] scalar = '0;
  logic          step = 1'b0;
  logic [DW-1:0] elem_a = '0;
  logic [DW-1:0] elem_b = '0;
  logic [3:0]    rm_cntr, src_a_idx, src_b_idx, wr_idx;
  logic          rm_cntr_done, busy, wr_en, done;
  logic [DW-1:0] wr_data, acc;

  int n_checks = 0;
  int n_fail = 0;

  vec_element_seq #(
    .VLEN   (NE),
    .DATA_W (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .z            (z),
    .bank         (bank),
    .rd           (rd),
    .scalar       (scalar),
    .step         (step),
    .elem_a       (elem_a),
    .elem_b       (elem_b),
    .rm_cntr      (rm_cntr),
    .rm_cntr_done (rm_cntr_done),
    .src_a_idx    (src_a_idx),
    .src_b_idx    (src_b_idx),
    .busy         (busy),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .acc          (acc),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operation in progress described by base register and element number.
  bit            m_run;
  int            m_op, m_base, m_k, m_rd;
  logic [DW-1:0] m_scalar, m_acc, m_wr_data;
  bit            m_wr_en, m_done;
  int            m_wr_idx;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_op = 0; m_base = 0; m_k = 0; m_rd = 0;
      m_scalar = '0; m_acc = '0; m_wr_data = '0; m_wr_en = 0; m_done = 0; m_wr_idx = 0;
    end else begin
      m_wr_en = 0;
      m_done  = 0;
      if (!m_run) begin
        if (start && op != 2'b00) begin
          m_run = 1; m_op = int'(op); m_rd = int'(rd); m_scalar = scalar;
          m_base = bank ? 5 : 0; m_k = 0;
          if (op == 2'b01 && z) m_acc = '0;
        end
      end else if (step) begin
        if (m_op == 1) begin
          m_acc = m_acc + elem_a * elem_b;
          if (m_k == NE - 1) begin
            m_wr_en = 1; m_wr_idx = m_rd; m_wr_data = m_acc;
          end
        end else begin
          m_wr_en = 1; m_wr_idx = m_base + m_k;
          m_wr_data = (m_op == 2) ? elem_a * m_scalar : elem_a + elem_b;
        end
        if (m_k == NE - 1) begin
          m_run = 0; m_done = 1;
        end else begin
          m_k++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("busy", DW'(busy), DW'(m_run));
      check("rm_cntr", DW'(rm_cntr), DW'(m_base + m_k));
      check("rm_cntr_done", DW'(rm_cntr_done), DW'(m_k == NE - 1));
      check("src_a_idx", DW'(src_a_idx), DW'(m_base + m_k));
      check("src_b_idx", DW'(src_b_idx), DW'((m_base + m_k + 5) % 10));
      check("acc", acc, m_acc);
      check("wr_en", DW'(wr_en), DW'(m_wr_en));
      check("done", DW'(done), DW'(m_done));
      if (m_wr_en) begin
        check("wr_idx", DW'(wr_idx), DW'(m_wr_idx));
        check("wr_data", wr_data, m_wr_data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [1:0] o, input logic zz, input logic bk,
                          input logic [3:0] r, input logic [DW-1:0] s);
    start = 1'b1; op = o; z = zz; bank = bk; rd = r; scalar = s;
    cyc(1);
    start = 1'b0; op = 2'b00; z = 1'b0; bank = 1'b0; rd = 4'd0; scalar = '0;
  endtask

  task automatic do_step(input logic [DW-1:0] a, input logic [DW-1:0] b);
    step = 1'b1; elem_a = a; elem_b = b;
    cyc(1);
    step = 1'b0; elem_a = '0; elem_b = '0;
  endtask

  initial begin
    rst = 1'b0;
    cyc(2);
    check("rst_busy", DW'(busy), 0);
    check("rst_wr_idx", DW'(wr_idx), 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b1;
    cyc(3);

    // Dot, z=1, bank 0, rd=7, a=1..5, b=2
    do_start(2'b01, 1'b1, 1'b0, 4'd7, '0);
    check("dot1_busy", DW'(busy), 1);
    check("dot1_acc0", acc, 0);
    for (int i = 1; i <= 5; i++) do_step(DW'(i), 2);
    check("dot1_wr_en", DW'(wr_en), 1);
    check("dot1_wr_idx", DW'(wr_idx), 7);
    check("dot1_wr_data", wr_data, 30);
    check("dot1_done", DW'(done), 1);
    check("dot1_acc", acc, 30);
    cyc(1);
    check("dot1_done_once", DW'(done), 0);

    // Dot, z=0, accumulator carried over
    do_start(2'b01, 1'b0, 1'b0, 4'd7, '0);
    check("dot2_acc_kept", acc, 30);
    for (int i = 1; i <= 5; i++) begin
      check("dot2_cntr_seq", DW'(rm_cntr), DW'(i - 1));
      do_step(DW'(i), 2);
    end
    check("dot2_wr_data", wr_data, 60);

    // Scalar-mul with idle gaps between steps
    do_start(2'b10, 1'b0, 1'b0, 4'd0, 3);
    for (int i = 0; i < 5; i++) begin
      do_step(DW'(10 + i), 0);
      check("smul_wr_idx", DW'(wr_idx), DW'(i));
      check("smul_wr_data", wr_data, DW'(30 + 3 * i));
      cyc(1);
      check("smul_gap_no_wr", DW'(wr_en), 0);
    end

    // Vector-add, bank 1, wraparound
    do_start(2'b11, 1'b0, 1'b1, 4'd0, '0);
    for (int i = 0; i < 5; i++) begin
      check("vadd_cntr_done", DW'(rm_cntr_done), DW'(i == 4));
      do_step(32'hFFFF_FFFF, 2);
      check("vadd_wr_idx", DW'(wr_idx), DW'(5 + i));
      check("vadd_wr_data", wr_data, 1);
    end
    cyc(1);

    // Ignored inputs: step in IDLE, op=00 start, start during RUN
    do_step(5, 5);
    check("idle_step_cntr", DW'(rm_cntr), 9);
    check("idle_step_wr", DW'(wr_en), 0);
    do_start(2'b00, 1'b1, 1'b0, 4'd3, '0);
    check("op0_busy", DW'(busy), 0);
    check("op0_acc", acc, 60);
    do_start(2'b10, 1'b0, 1'b0, 4'd0, 3);
    do_start(2'b11, 1'b0, 1'b1, 4'd0, 9);
    check("run_start_cntr", DW'(rm_cntr), 0);
    do_step(7, 100);
    check("run_start_data", wr_data, 21);
    for (int i = 0; i < 4; i++) do_step(1, 1);
    cyc(2);

    // start and step together in IDLE: only start takes effect
    start = 1'b1; op = 2'b10; scalar = 4; step = 1'b1; elem_a = 9;
    cyc(1);
    start = 1'b0; op = 2'b00; scalar = '0; step = 1'b0; elem_a = '0;
    check("startstep_cntr", DW'(rm_cntr), 0);
    check("startstep_wr", DW'(wr_en), 0);

    // Reset mid-RUN after two steps
    do_step(2, 0);
    do_step(3, 0);
    rst = 1'b0;
    #2;
    check("midrst_busy", DW'(busy), 0);
    check("midrst_cntr", DW'(rm_cntr), 0);
    check("midrst_done", DW'(done), 0);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    do_start(2'b10, 1'b0, 1'b0, 4'd0, 5);
    for (int i = 0; i < 5; i++) do_step(DW'(i + 1), 0);
    check("fresh_wr_data", wr_data, 25);
    check("fresh_done", DW'(done), 1);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
